// File: rtl/bcd_conv_sched.sv
// Shared iterative binary-to-BCD converter (double dabble, one shift per clock)
// with a two-requester round-robin arbiter in front of the engine.
module bcd_conv_sched #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [IN_W-1:0]       hex0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [IN_W-1:0]       hex1,
    output logic                  gnt1,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  bcd_id,
    output logic                  ovf,
    output logic                  busy
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(IN_W + 1);
    // Largest operand that still fits in DIGITS decimal digits.
    localparam logic [63:0] MaxBcd = (64'd10 ** DIGITS) - 64'd1;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e          state_q, state_d;
    logic [IN_W-1:0] bin_q, bin_d;
    logic [BW-1:0]   bsr_q, bsr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            ovfp_q, ovfp_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            id_q, id_d;
    logic            ovf_q, ovf_d;

    logic                 pick1;
    logic [IN_W-1:0]      hex_sel;
    logic [63:0]          hex_ext;
    logic [BW-1:0]        adj;
    logic [BW+IN_W-1:0]   shifted;

    // Arbitration choice and add-3 adjust / shift datapath.
    always_comb begin
        // Requester 1 wins when alone, or on a tie when requester 0 went last.
        pick1   = req1 & (~req0 | ~last_q);
        hex_sel = pick1 ? hex1 : hex0;
        hex_ext = 64'(hex_sel);
        adj     = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj[4*i +: 4] = (bsr_q[4*i +: 4] >= 4'd5) ? bsr_q[4*i +: 4] + 4'd3
                                                      : bsr_q[4*i +: 4];
        end
        shifted = {adj, bin_q} << 1;
    end

    // Next-state and next-value logic for the FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bsr_d   = bsr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ovfp_d  = ovfp_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        bcd_d   = bcd_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    last_d  = pick1;
                    bin_d   = hex_sel;
                    bsr_d   = '0;
                    ovfp_d  = (hex_ext > MaxBcd);
                    cnt_d   = CW'(IN_W);
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    state_d = StConv;
                end
            end
            StConv: begin
                bsr_d = shifted[BW+IN_W-1:IN_W];
                bin_d = shifted[IN_W-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = ovfp_q ? {DIGITS{4'h9}} : shifted[BW+IN_W-1:IN_W];
                    ovf_d   = ovfp_q;
                    id_d    = last_q;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bsr_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            ovfp_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            bcd_q   <= '0;
            id_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bsr_q   <= bsr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ovfp_q  <= ovfp_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            bcd_q   <= bcd_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign bcd       = bcd_q;
    assign bcd_id    = id_q;
    assign ovf       = ovf_q;
    assign bcd_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: grants push decimal-model expectations,
// a separate monitor pops and compares on every bcd_valid.
module tb_bcd_conv_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] hex0, hex1;
    logic        gnt0, gnt1;
    logic [31:0] bcd;
    logic        bcd_valid, bcd_id, ovf, busy;

    bcd_conv_sched #(.IN_W(32), .DIGITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .hex0      (hex0),
        .gnt0      (gnt0),
        .req1      (req1),
        .hex1      (hex1),
        .gnt1      (gnt1),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .bcd_id    (bcd_id),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bcd;
        logic        id;
        logic        ovf;
        int          gc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Decimal reference: saturate above 99,999,999, else peel digits with % and /.
    function automatic exp_t model(input logic id, input logic [31:0] v, input int gc);
        exp_t      e;
        longint    x;
        x      = longint'(v);
        e.id   = id;
        e.gc   = gc;
        e.bcd  = '0;
        e.ovf  = (x > 64'd99_999_999);
        if (e.ovf) e.bcd = 32'h9999_9999;
        else begin
            for (int i = 0; i < 8; i++) begin
                e.bcd[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return e;
    endfunction

    // Grant monitor: record the expected result for whichever operand was captured.
    always @(posedge clk) begin
        #1;
        if (rst_n && (gnt0 || gnt1)) begin
            check("gnt_onehot", 64'(gnt0 & gnt1), 64'd0);
            if (gnt0) sb.push_back(model(1'b0, hex0, cyc));
            if (gnt1) sb.push_back(model(1'b1, hex1, cyc));
        end
    end

    // Result monitor: every completion must match the oldest outstanding job.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && bcd_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: bcd_valid=1 bcd=%0h, required no result (cycle %0d)",
                         bcd, cyc);
            end else begin
                e = sb.pop_front();
                check("bcd", 64'(bcd), 64'(e.bcd));
                check("bcd_id", 64'(bcd_id), 64'(e.id));
                check("ovf", 64'(ovf), 64'(e.ovf));
                check("valid_latency", 64'(cyc - e.gc), 64'd32);
            end
        end
    end

    // Raise one request and hold it until granted; reports grant cycle and wait.
    task automatic issue(input logic id, input logic [31:0] v, output int gc, output int w);
        int start;
        start = cyc;
        gc    = -1;
        w     = -1;
        if (id) begin hex1 = v; req1 = 1'b1; end
        else begin hex0 = v; req0 = 1'b1; end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((id && gnt1) || (!id && gnt0)) begin
                gc = cyc;
                w  = cyc - start;
                break;
            end
        end
        if (id) req1 = 1'b0;
        else req0 = 1'b0;
        if (gc < 0) begin
            n_total++;
            $display("FAIL grant_timeout: no gnt%0d, required within 200 cycles", id);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, required idle", busy, sb.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gc, w, vc, cnt, g1, start, ng;
        int          gid[3];
        int          gcy[3];
        logic [31:0] r1vals[4];
        logic [31:0] v;
        r1vals = '{32'd0, 32'd2, 32'd36, 32'd99_999_999};

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; hex0 = '0; hex1 = '0;
        repeat (3) @(negedge clk);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_flags", 64'({gnt0, gnt1, bcd_valid, ovf, busy, bcd_id}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic conversion with timing: gnt T+1, valid T+33, idle T+34.
        issue(1'b0, 32'd40, gc, w);
        check("t1_gnt_lat", 64'(w), 64'd1);
        vc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bcd_valid) begin vc = cyc; break; end
        end
        check("t1_valid_at", 64'(vc - gc), 64'd32);
        check("t1_bcd", 64'(bcd), 64'h40);
        @(negedge clk);
        check("t1_busy_low", 64'(busy), 64'd0);

        // Saturation and its clearing on the next in-range conversion.
        issue(1'b0, 32'd100_000_000, gc, w);
        wait_idle();
        repeat (3) @(negedge clk);
        check("ovf_hold", 64'({ovf, bcd}), {31'd0, 1'b1, 32'h9999_9999});
        issue(1'b0, 32'hFFFF_FFFF, gc, w);
        wait_idle();
        issue(1'b0, 32'd16, gc, w);
        wait_idle();
        check("ovf_clear", 64'({ovf, bcd}), 64'h16);

        // Requester 1 single conversions, leaving requester 1 as last owner.
        foreach (r1vals[k]) begin
            issue(1'b1, r1vals[k], gc, w);
            wait_idle();
        end

        // Both held: grants alternate 0,1,0 with IN_W+2 spacing.
        hex0 = 32'd8; hex1 = 32'd32; req0 = 1'b1; req1 = 1'b1;
        start = cyc; ng = 0;
        for (int i = 0; i < 200 && ng < 3; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                gid[ng] = gnt1 ? 1 : 0;
                gcy[ng] = cyc;
                ng++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_count", 64'(ng), 64'd3);
        if (ng == 3) begin
            check("rr_order", 64'({gid[0][0], gid[1][0], gid[2][0]}), 64'b010);
            check("rr_first_lat", 64'(gcy[0] - start), 64'd1);
            check("rr_gap1", 64'(gcy[1] - gcy[0]), 64'd34);
            check("rr_gap2", 64'(gcy[2] - gcy[1]), 64'd34);
        end
        wait_idle();

        // A one-cycle req0 inside busy is lost.
        issue(1'b1, 32'd55, g1, w);
        repeat (4) @(negedge clk);
        hex0 = 32'd7; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt0) cnt++;
        end
        check("pulse_no_gnt", 64'(cnt), 64'd0);
        wait_idle();

        // A held req0 during busy is granted only once IDLE is re-entered.
        issue(1'b1, 32'd66, g1, w);
        repeat (4) @(negedge clk);
        issue(1'b0, 32'd77, gc, w);
        check("wait_gnt_at_idle", 64'(gc - g1), 64'd34);
        wait_idle();

        // Reset at CONV iteration 10 aborts the job and restores arbitration.
        issue(1'b0, 32'd1234, gc, w);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_bcd", 64'(bcd), 64'd0);
        check("abort_flags", 64'({bcd_valid, busy, ovf, bcd_id}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        hex0 = 32'd4321; hex1 = 32'd9; req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        check("post_rst_tie", 64'({gnt0, gnt1}), 64'b10);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();
        issue(1'b0, 32'd5, gc, w);
        check("post_rst_gnt_lat", 64'(w), 64'd1);
        wait_idle();

        // Randomized back-to-back traffic from both requesters.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: v = 32'($urandom_range(0, 99));
                1: v = 32'($urandom_range(0, 99_999_999));
                2: v = 32'd99_999_990 + 32'($urandom_range(0, 20));
                default: v = $urandom;
            endcase
            issue(1'($urandom_range(0, 1)), v, gc, w);
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
